// File: rtl/vect_decode_queue_pkg.sv
// vect_decode_queue_pkg: shared vector decode types, opcodes and vtype field positions
package vect_decode_queue_pkg;
  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOAD  = 2'b01,
    CLS_STORE = 2'b10,
    CLS_CFG   = 2'b11
  } instr_class_e;
  // Storage widths cover XLEN up to 64 and VLEN up to 32768; outputs slice them down
  localparam int XLEN_MAX = 64;
  localparam int VLW_MAX = 16;
  localparam logic [6:0] OP_VLOAD = 7'b0000111;
  localparam logic [6:0] OP_VSTORE = 7'b0100111;
  localparam logic [6:0] OP_VARITH = 7'b1010111;
  localparam logic [2:0] F3_OPFVV = 3'b001;
  localparam logic [2:0] F3_OPIVI = 3'b011;
  localparam logic [2:0] F3_OPFVF = 3'b101;
  localparam logic [2:0] F3_OPCFG = 3'b111;
  localparam int VT_LMUL_LSB = 0;
  localparam int VT_SEW_LSB = 3;
  localparam int VT_VILL = 7;
  typedef struct packed {
    instr_class_e          cls;
    logic [5:0]            funct6;
    logic [2:0]            funct3;
    logic                  vm;
    logic [4:0]            vs1;
    logic [4:0]            vs2;
    logic [4:0]            vd;
    logic [XLEN_MAX-1:0]   scalar;
    logic [XLEN_MAX-1:0]   rs2;
    logic                  illegal;
    logic [VLW_MAX-1:0]    vl;
  } decoded_instr_t;
endpackage

// File: rtl/vect_instr_decode.sv
// vect_instr_decode: combinational raw vector instruction + scalar operands to decoded record
module vect_instr_decode import vect_decode_queue_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output decoded_instr_t  dec
);
  logic [2:0] f3;
  logic ld, st, ar, illegal;
  assign f3 = instr[14:12];
  assign ld = instr[6:0] == OP_VLOAD;
  assign st = instr[6:0] == OP_VSTORE;
  assign ar = instr[6:0] == OP_VARITH;
  // memory forms reject segment (nf) and mew; float arithmetic is unsupported
  assign illegal = !(ld || st || ar) || (ar && (f3 == F3_OPFVV || f3 == F3_OPFVF)) ||
                   ((ld || st) && instr[31:28] != 4'b0);
  always_comb begin
    dec = '0;
    dec.cls = illegal ? CLS_ARITH : ld ? CLS_LOAD : st ? CLS_STORE : f3 == F3_OPCFG ? CLS_CFG : CLS_ARITH;
    dec.funct6 = instr[31:26];
    dec.funct3 = f3;
    dec.vm = instr[25];
    dec.vs2 = instr[24:20];
    dec.vs1 = instr[19:15];
    dec.vd = instr[11:7];
    dec.scalar = (ar && !illegal && f3 == F3_OPIVI) ? XLEN_MAX'(signed'(instr[19:15])) : XLEN_MAX'(rs1);
    dec.rs2 = XLEN_MAX'(rs2);
    dec.illegal = illegal;
  end
endmodule

// File: rtl/vect_decode_queue.sv
// vect_decode_queue: vector decode FIFO; VECT_DECQ_CFG_EN executes vset{i}vl{i} in-block
module vect_decode_queue import vect_decode_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter int VLEN = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [31:0]               in_instr_i,
  input  logic [XLEN-1:0]           in_rs1_i,
  input  logic [XLEN-1:0]           in_rs2_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [1:0]                out_class_o,
  output logic [5:0]                out_funct6_o,
  output logic [2:0]                out_funct3_o,
  output logic                      out_vm_o,
  output logic [4:0]                out_vs1_o,
  output logic [4:0]                out_vs2_o,
  output logic [4:0]                out_vd_o,
  output logic [XLEN-1:0]           out_scalar_o,
  output logic [XLEN-1:0]           out_rs2_o,
  output logic                      out_illegal_o,
  output logic [$clog2(VLEN):0]     out_vl_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic [$clog2(VLEN):0]     vl_o,
  output logic [7:0]                vtype_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int VLW = $clog2(VLEN) + 1;
  decoded_instr_t dec, ent, head;
  decoded_instr_t mem [DEPTH];
  logic cfg, push, pop;
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [VLW-1:0] vl_q;
  logic [7:0] vtype_q;
  vect_instr_decode #(.XLEN(XLEN)) u_dec (
    .instr(in_instr_i),
    .rs1(in_rs1_i),
    .rs2(in_rs2_i),
    .dec(dec)
  );
`ifdef VECT_DECQ_CFG_EN
  logic ivli, vsetvl, ok, keep;
  logic [6:0] vt;
  logic [VLW-1:0] vlmax, vl_n;
  logic [XLEN-1:0] avl;
  assign cfg = in_valid_i && in_ready_o && !flush_i && dec.cls == CLS_CFG;
  always_comb begin
    ivli = in_instr_i[31:30] == 2'b11;
    vsetvl = in_instr_i[31:25] == 7'b1000000;
    vt = vsetvl ? in_rs2_i[6:0] : in_instr_i[26:20];
    ok = (!in_instr_i[31] || ivli || vsetvl) && vt[VT_SEW_LSB+:3] <= 3'd2 && vt[VT_LMUL_LSB+:3] == 3'd0;
    vlmax = VLW'(VLEN >> (3 + vt[VT_SEW_LSB+:3]));
    avl = ivli ? XLEN'(in_instr_i[19:15]) : in_instr_i[19:15] != 5'd0 ? in_rs1_i : XLEN'(vlmax);
    keep = !ivli && in_instr_i[19:15] == 5'd0 && in_instr_i[11:7] == 5'd0;
    vl_n = !ok ? '0 : keep ? vl_q : avl < XLEN'(vlmax) ? VLW'(avl) : vlmax;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      vl_q <= '0;
      vtype_q <= 8'h80;
    end else if (cfg) begin
      vl_q <= vl_n;
      vtype_q <= ok ? {1'b0, vt} : 8'h80;
    end
`else
  assign cfg = 1'b0;
  assign vl_q = '0;
  assign vtype_q = 8'h80;
`endif
  assign push = in_valid_i && in_ready_o && !cfg;
  assign pop = out_valid_o && out_ready_i;
  always_comb begin
    ent = dec;
    ent.vl = VLW_MAX'(vl_q);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= ent;
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  assign head = mem[rp];
  assign count_o = cnt;
  assign in_ready_o = cnt != CW'(DEPTH);
  assign out_valid_o = cnt != '0;
  assign out_class_o = head.cls;
  assign out_funct6_o = head.funct6;
  assign out_funct3_o = head.funct3;
  assign out_vm_o = head.vm;
  assign out_vs1_o = head.vs1;
  assign out_vs2_o = head.vs2;
  assign out_vd_o = head.vd;
  assign out_scalar_o = head.scalar[XLEN-1:0];
  assign out_rs2_o = head.rs2[XLEN-1:0];
  assign out_illegal_o = head.illegal;
  assign out_vl_o = head.vl[VLW-1:0];
  assign vl_o = vl_q;
  assign vtype_o = vtype_q;
endmodule

// File: tb/tb_vect_decode_queue.sv
// tb_vect_decode_queue: randomized scoreboard bench with a queue-based reference model
module tb_vect_decode_queue;
  localparam int DEPTH = 4;
  localparam int VLEN = 256;
  logic clk_i = 0, rst_i = 1, flush_i = 0, in_valid_i = 0, out_ready_i = 0;
  logic [31:0] in_instr_i = 0, in_rs1_i = 0, in_rs2_i = 0;
  logic in_ready_o, out_valid_o, out_vm_o, out_illegal_o;
  logic [1:0] out_class_o;
  logic [5:0] out_funct6_o;
  logic [2:0] out_funct3_o, count_o;
  logic [4:0] out_vs1_o, out_vs2_o, out_vd_o;
  logic [31:0] out_scalar_o, out_rs2_o;
  logic [8:0] out_vl_o, vl_o;
  logic [7:0] vtype_o;
  typedef struct {
    logic [1:0] cls; logic [5:0] f6; logic [2:0] f3; logic vm;
    logic [4:0] vs1, vs2, vd; logic [31:0] sc, r2; logic ill; logic [8:0] vl;
  } exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0;
  bit pend_pop = 0;
  logic [8:0] m_vl = 0;
  logic [7:0] m_vtype = 8'h80;
  vect_decode_queue #(.DEPTH(DEPTH), .XLEN(32), .VLEN(VLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_instr_i(in_instr_i), .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_class_o(out_class_o), .out_funct6_o(out_funct6_o),
    .out_funct3_o(out_funct3_o), .out_vm_o(out_vm_o), .out_vs1_o(out_vs1_o), .out_vs2_o(out_vs2_o),
    .out_vd_o(out_vd_o), .out_scalar_o(out_scalar_o), .out_rs2_o(out_rs2_o), .out_illegal_o(out_illegal_o),
    .out_vl_o(out_vl_o), .count_o(count_o), .vl_o(vl_o), .vtype_o(vtype_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(string nm, logic [63:0] got, logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", nm, got, want, $time);
    end
  endtask
  function automatic logic [31:0] mk(logic [5:0] f6, logic vm, logic [4:0] vs2, logic [4:0] vs1,
                                     logic [2:0] f3, logic [4:0] vd, logic [6:0] op);
    return {f6, vm, vs2, vs1, f3, vd, op};
  endfunction
  function automatic exp_t model(logic [31:0] ins, logic [31:0] a, logic [31:0] b, logic [8:0] vl);
    exp_t e;
    e.f6 = ins[31:26]; e.vm = ins[25]; e.vs2 = ins[24:20]; e.vs1 = ins[19:15];
    e.f3 = ins[14:12]; e.vd = ins[11:7]; e.sc = a; e.r2 = b; e.vl = vl; e.cls = 0; e.ill = 0;
    case (ins[6:0])
      7'h07: begin e.cls = 1; e.ill = ins[31:28] != 0; end
      7'h27: begin e.cls = 2; e.ill = ins[31:28] != 0; end
      7'h57: begin
        e.ill = e.f3 == 1 || e.f3 == 5;
        e.cls = e.f3 == 7 ? 3 : 0;
        if (e.f3 == 3) e.sc = {{27{ins[19]}}, ins[19:15]};
      end
      default: e.ill = 1;
    endcase
    if (e.ill) e.cls = 0;
    return e;
  endfunction
  task automatic model_cfg(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    logic [6:0] vt;
    bit form = 1, ivli = 0;
    longint avl, vlmax;
    if (!ins[31]) vt = ins[26:20];
    else if (ins[31:30] == 2'b11) begin vt = ins[26:20]; ivli = 1; end
    else if (ins[31:25] == 7'b1000000) vt = b[6:0];
    else begin vt = 0; form = 0; end
    if (!form || vt[5:3] > 2 || vt[2:0] != 0) begin
      m_vl = 0;
      m_vtype = 8'h80;
    end else begin
      vlmax = VLEN / (8 << vt[5:3]);
      m_vtype = {1'b0, vt};
      if (ivli || ins[19:15] != 0 || ins[11:7] != 0) begin
        avl = ivli ? longint'(ins[19:15]) : ins[19:15] != 0 ? longint'(a) : vlmax;
        m_vl = 9'(avl < vlmax ? avl : vlmax);
      end
    end
  endtask
  // reference model: decides acceptance from its own occupancy (pre-pop) and records expectations
  always begin
    exp_t e;
    @(negedge clk_i);
    #2;
    if (rst_i) begin
      exp_q.delete();
      m_vl = 0;
      m_vtype = 8'h80;
    end else if (flush_i) exp_q.delete();
    else if (in_valid_i && exp_q.size() + int'(pend_pop) < DEPTH) begin
      e = model(in_instr_i, in_rs1_i, in_rs2_i, m_vl);
`ifdef VECT_DECQ_CFG_EN
      if (e.cls == 3) model_cfg(in_instr_i, in_rs1_i, in_rs2_i);
      else exp_q.push_back(e);
`else
      exp_q.push_back(e);
`endif
    end
    pend_pop = 0;
  end
  always begin
    exp_t e;
    @(negedge clk_i);
    if (!rst_i) begin
      check("count", count_o, exp_q.size());
      check("in_ready", in_ready_o, exp_q.size() < DEPTH);
      check("out_valid", out_valid_o, exp_q.size() != 0);
      check("vl_o", vl_o, m_vl);
      check("vtype_o", vtype_o, m_vtype);
      if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pend_pop = 1;
        check("class", out_class_o, e.cls);
        check("funct6", out_funct6_o, e.f6);
        check("funct3", out_funct3_o, e.f3);
        check("vm", out_vm_o, e.vm);
        check("vs1", out_vs1_o, e.vs1);
        check("vs2", out_vs2_o, e.vs2);
        check("vd", out_vd_o, e.vd);
        check("scalar", out_scalar_o, e.sc);
        check("rs2", out_rs2_o, e.r2);
        check("illegal", out_illegal_o, e.ill);
        check("out_vl", out_vl_o, e.vl);
      end
    end
  end
  task automatic drive(bit v, bit r, logic [31:0] ins = 0, logic [31:0] a = 0, logic [31:0] b = 0);
    in_valid_i = v; out_ready_i = r; in_instr_i = ins; in_rs1_i = a; in_rs2_i = b;
    @(posedge clk_i);
    #1;
  endtask
  function automatic logic [31:0] plain();
    logic [31:0] r = $urandom;
    logic [2:0] f3s[5] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6};
    if ($urandom_range(0, 2) == 0) return {4'b0, r[27:7], 7'h07};
    return {r[31:15], f3s[$urandom_range(0, 4)], r[11:7], 7'h57};
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: return {r[31:7], 7'h57};
      5: return {4'b0, r[27:7], 7'h07};
      6: return {r[31:7], 7'h07};
      7: return {4'b0, r[27:7], 7'h27};
      8: return r;
      default: return {r[31:15], 3'b111, r[11:7], 7'h57};
    endcase
  endfunction
  initial begin
    logic [31:0] vsetvli, vsew3;
    vsetvli = {1'b0, 11'h010, 5'd5, 3'b111, 5'd1, 7'h57};
    vsew3 = {1'b0, 11'h018, 5'd5, 3'b111, 5'd1, 7'h57};
    #2;
    check("rst_count", count_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_ready", in_ready_o, 1);
    check("rst_fields", {out_class_o, out_funct6_o, out_vd_o, out_scalar_o, out_illegal_o}, 0);
    check("rst_out_vl", out_vl_o, 0);
    check("rst_vl", vl_o, 0);
    check("rst_vtype", vtype_o, 8'h80);
    drive(0, 0);
    drive(0, 0);
    rst_i = 0;
    drive(1, 0, 32'h0220_80D7, 32'h11, 32'h22);
    check("vadd_valid", out_valid_o, 1);
    check("vadd_class", out_class_o, 0);
    check("vadd_f6", out_funct6_o, 0);
    check("vadd_vs2", out_vs2_o, 2);
    check("vadd_vs1", out_vs1_o, 1);
    check("vadd_vd", out_vd_o, 1);
    check("vadd_vm", out_vm_o, 1);
    check("vadd_ill", out_illegal_o, 0);
    drive(0, 1);
    for (int i = 0; i < 4; i++) drive(1, 0, plain(), $urandom, $urandom);
    check("full_count", count_o, 4);
    check("full_ready", in_ready_o, 0);
    drive(1, 0, plain(), $urandom, $urandom);
    check("refused_count", count_o, 4);
    for (int i = 0; i < 4; i++) drive(0, 1);
    check("drained", count_o, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, plain(), $urandom, $urandom);
    drive(1, 1, plain(), $urandom, $urandom);
    check("full_pushpop", count_o, 3);
    drive(0, 1);
    drive(1, 1, plain(), $urandom, $urandom);
    check("mid_pushpop", count_o, 2);
    drive(0, 1);
    drive(0, 1);
    check("drained2", count_o, 0);
    drive(1, 0, mk(6'd0, 1, 5'd3, 5'b11110, 3'b011, 5'd4, 7'h57), 32'h1234, 0);
    check("opivi_scalar", out_scalar_o, 32'hFFFF_FFFE);
    drive(0, 1);
    drive(1, 0, mk(6'd0, 1, 5'd2, 5'd1, 3'b000, 5'd1, 7'b0110011));
    check("badop_ill", out_illegal_o, 1);
    check("badop_class", out_class_o, 0);
    drive(0, 1);
    drive(1, 0, mk(6'b001000, 1, 5'd0, 5'd1, 3'b110, 5'd2, 7'h07));
    check("nf_ill", out_illegal_o, 1);
    drive(0, 1);
    drive(1, 0, plain(), $urandom, $urandom);
    drive(1, 0, plain(), $urandom, $urandom);
    #2 rst_i = 1;
    #1;
    check("async_rst_count", count_o, 0);
    check("async_rst_valid", out_valid_o, 0);
    drive(0, 0);
    rst_i = 0;
    drive(1, 0, vsetvli, 100, 0);
`ifdef VECT_DECQ_CFG_EN
    check("cfg_vl", vl_o, 8);
    check("cfg_notqueued", count_o, 0);
    drive(1, 0, mk(6'd0, 1, 5'd0, 5'd6, 3'b110, 5'd8, 7'h07), 32'h1000);
    check("vle_vl", out_vl_o, 8);
    drive(0, 1);
    drive(1, 0, vsew3, 100, 0);
    check("vill_vl", vl_o, 0);
    check("vill_vtype", vtype_o, 8'h80);
    drive(1, 0, vsetvli, 100, 0);
`else
    check("cfg_class", out_class_o, 3);
    check("cfg_vl_tied", vl_o, 0);
    check("cfg_vtype_tied", vtype_o, 8'h80);
    drive(0, 1);
`endif
    for (int i = 0; i < 3; i++) drive(1, 0, plain(), $urandom, $urandom);
    check("pre_flush", count_o, 3);
    flush_i = 1;
    drive(1, 0, plain(), $urandom, $urandom);
    flush_i = 0;
    check("flush_count", count_o, 0);
    check("flush_valid", out_valid_o, 0);
`ifdef VECT_DECQ_CFG_EN
    check("flush_vl_kept", vl_o, 8);
`else
    check("flush_vl_kept", vl_o, 0);
`endif
    repeat (400) begin
      bit fl;
      fl = $urandom_range(0, 40) == 0;
      flush_i = fl;
      drive(!fl && $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, rnd_instr(),
            $urandom_range(0, 1) == 1 ? $urandom : $urandom_range(0, 40), $urandom);
    end
    flush_i = 0;
    repeat (DEPTH + 2) drive(0, 1);
    check("final_empty", count_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
